// File: rtl/decoder_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter_if
//   Bundle of signals between the round-robin arbiter, its eight requesting
//   agents and the shared 3-to-8 decoder.
//
//   requestIn    8  level request per agent, bit i = agent i
//   numberOut    3  decoder select pins {bit2,bit1,bit0} = current winner
//   enableB0Out  1  decoder active-low enable 0
//   enableB1Out  1  decoder active-low enable 1
//   enable2Out   1  decoder active-high enable
//   grantOut     8  one-hot grant, all zero when nothing is granted
//   busyOut      1  high while a grant or guard interval is in progress
//
//   master: arbiter side (drives everything except requestIn)
//   slave : agent/decoder side
// ---------------------------------------------------------------------------
interface decoder_rr_arbiter_if;
    logic [7:0] requestIn;
    logic [2:0] numberOut;
    logic       enableB0Out;
    logic       enableB1Out;
    logic       enable2Out;
    logic [7:0] grantOut;
    logic       busyOut;

    modport master (
        input  requestIn,
        output numberOut,
        output enableB0Out,
        output enableB1Out,
        output enable2Out,
        output grantOut,
        output busyOut
    );

    modport slave (
        output requestIn,
        input  numberOut,
        input  enableB0Out,
        input  enableB1Out,
        input  enable2Out,
        input  grantOut,
        input  busyOut
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter
//   Round-robin arbiter that shares one 74HC138-style 3-to-8 decoder among
//   eight requesters. A winner is selected, the decoder number/enable pins are
//   driven for the duration of the grant, and a guard interval with the
//   decoder disabled is inserted before any following grant.
//
//   Ports
//     clk     rising-edge clock
//     rst     asynchronous active-high reset
//     arbBus  decoder_rr_arbiter_if.master (requests in, decoder pins,
//             one-hot grant and busy out)
//
//   Parameters
//     HOLD_CYCLES   maximum consecutive grant cycles (timeout build only)
//     GUARD_CYCLES  decoder-disabled cycles between grants (>=1)
//     COUNT_WIDTH   width of the hold/guard counters
//
//   Build option
//     ARB_TIMEOUT_EN  when defined, a grant also ends after HOLD_CYCLES
//                     cycles; otherwise it lasts until the request drops.
// ---------------------------------------------------------------------------
module decoder_rr_arbiter #(
    parameter int HOLD_CYCLES  = 16,
    parameter int GUARD_CYCLES = 1,
    parameter int COUNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    decoder_rr_arbiter_if.master  arbBus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GUARD = 2'b10
    } arbState_t;

    localparam logic [COUNT_WIDTH-1:0] HOLD_LAST  = COUNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] GUARD_LAST = COUNT_WIDTH'(GUARD_CYCLES - 1);

    arbState_t              stateReg;
    logic [2:0]             numberReg;
    logic                   enableB0Reg;
    logic                   enableB1Reg;
    logic                   enable2Reg;
    logic [7:0]             grantReg;
    logic                   busyReg;
    logic [2:0]             lastGrantReg;
    logic [COUNT_WIDTH-1:0] holdCntReg;
    logic [COUNT_WIDTH-1:0] guardCntReg;

    // Round-robin search: rotate the request vector so that bit 0 is the
    // agent just after the previous winner, then take the lowest set bit.
    logic [2:0] searchStart;
    logic [7:0] rotatedReq;
    logic [2:0] winOffset;
    logic [2:0] winner;
    logic       anyRequest;

    assign searchStart = lastGrantReg + 3'd1;
    assign anyRequest  = |arbBus.requestIn;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rotate
            logic [2:0] srcIdx;
            assign srcIdx         = searchStart + 3'(gi);
            assign rotatedReq[gi] = arbBus.requestIn[srcIdx];
        end
    endgenerate

    always_comb begin
        winOffset = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rotatedReq[i]) begin
                winOffset = 3'(i);
            end
        end
    end

    assign winner = searchStart + winOffset;

    // Grant release: holder dropped its request, or (timeout build) the
    // holder has used up its HOLD_CYCLES.
    logic timeoutHit;
    logic releaseNow;

`ifdef ARB_TIMEOUT_EN
    assign timeoutHit = (holdCntReg == HOLD_LAST);
`else
    assign timeoutHit = 1'b0;
`endif

    assign releaseNow = !arbBus.requestIn[numberReg] || timeoutHit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg     <= IDLE;
            numberReg    <= 3'd0;
            enableB0Reg  <= 1'b1;
            enableB1Reg  <= 1'b1;
            enable2Reg   <= 1'b0;
            grantReg     <= 8'd0;
            busyReg      <= 1'b0;
            lastGrantReg <= 3'd7;
            holdCntReg   <= '0;
            guardCntReg  <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (anyRequest) begin
                        stateReg    <= GRANT;
                        numberReg   <= winner;
                        enableB0Reg <= 1'b0;
                        enableB1Reg <= 1'b0;
                        enable2Reg  <= 1'b1;
                        grantReg    <= 8'd1 << winner;
                        busyReg     <= 1'b1;
                        holdCntReg  <= '0;
                    end
                end

                GRANT: begin
                    if (releaseNow) begin
                        stateReg     <= GUARD;
                        enableB0Reg  <= 1'b1;
                        enableB1Reg  <= 1'b1;
                        enable2Reg   <= 1'b0;
                        grantReg     <= 8'd0;
                        lastGrantReg <= numberReg;
                        holdCntReg   <= '0;
                        guardCntReg  <= '0;
                    end else if (holdCntReg != HOLD_LAST) begin
                        // Saturates at HOLD_LAST; only the timeout build acts on it.
                        holdCntReg <= holdCntReg + 1'b1;
                    end
                end

                GUARD: begin
                    if (guardCntReg == GUARD_LAST) begin
                        guardCntReg <= '0;
                        if (anyRequest) begin
                            stateReg    <= GRANT;
                            numberReg   <= winner;
                            enableB0Reg <= 1'b0;
                            enableB1Reg <= 1'b0;
                            enable2Reg  <= 1'b1;
                            grantReg    <= 8'd1 << winner;
                            holdCntReg  <= '0;
                        end else begin
                            stateReg <= IDLE;
                            busyReg  <= 1'b0;
                        end
                    end else begin
                        guardCntReg <= guardCntReg + 1'b1;
                    end
                end

                default: begin
                    stateReg     <= IDLE;
                    numberReg    <= 3'd0;
                    enableB0Reg  <= 1'b1;
                    enableB1Reg  <= 1'b1;
                    enable2Reg   <= 1'b0;
                    grantReg     <= 8'd0;
                    busyReg      <= 1'b0;
                    lastGrantReg <= 3'd7;
                    holdCntReg   <= '0;
                    guardCntReg  <= '0;
                end
            endcase
        end
    end

    assign arbBus.numberOut   = numberReg;
    assign arbBus.enableB0Out = enableB0Reg;
    assign arbBus.enableB1Out = enableB1Reg;
    assign arbBus.enable2Out  = enable2Reg;
    assign arbBus.grantOut    = grantReg;
    assign arbBus.busyOut     = busyReg;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//   Self-checking bench for decoder_rr_arbiter. Each driven request vector is
//   run through a behavioural model; the expected outputs after the next clock
//   edge are queued and compared once the DUT has produced them.
// ---------------------------------------------------------------------------
module tb_decoder_rr_arbiter;

    localparam int HOLD_CYCLES  = 4;
    localparam int GUARD_CYCLES = 1;
    localparam int COUNT_WIDTH  = 5;

    logic clk;
    logic rst;

    decoder_rr_arbiter_if arbBus ();

    decoder_rr_arbiter #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES),
        .COUNT_WIDTH  (COUNT_WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .arbBus (arbBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;
    int cycleNum   = 0;

    // Expected output word: {number[2:0], enables[2:0], grant[7:0], busy}
    logic [14:0] expQueue[$];

    // Behavioural model state: 0 idle, 1 grant, 2 guard
    int         mState;
    logic [2:0] mNum;
    logic [2:0] mLast;
    int         mHold;
    int         mGuard;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycleNum, obs, exp);
        end
    endtask

    function automatic logic [2:0] modelWinner(input logic [7:0] req, input logic [2:0] last);
        logic [2:0] idx;
        for (int k = 1; k <= 8; k++) begin
            idx = 3'((int'(last) + k) % 8);
            if (req[idx]) return idx;
        end
        return 3'd0;
    endfunction

    task automatic modelReset();
        mState = 0;
        mNum   = 3'd0;
        mLast  = 3'd7;
        mHold  = 0;
        mGuard = 0;
    endtask

    task automatic modelStep(input logic [7:0] req, input logic inReset);
        logic timedOut;
        if (inReset) begin
            modelReset();
        end else begin
            case (mState)
                0: if (req != 8'd0) begin
                    mState = 1;
                    mNum   = modelWinner(req, mLast);
                    mHold  = 0;
                end
                1: begin
`ifdef ARB_TIMEOUT_EN
                    timedOut = (mHold == HOLD_CYCLES - 1);
`else
                    timedOut = 1'b0;
`endif
                    if (!req[mNum] || timedOut) begin
                        mState = 2;
                        mLast  = mNum;
                        mHold  = 0;
                        mGuard = 0;
                    end else begin
                        mHold = mHold + 1;
                    end
                end
                default: begin
                    if (mGuard == GUARD_CYCLES - 1) begin
                        mGuard = 0;
                        if (req != 8'd0) begin
                            mState = 1;
                            mNum   = modelWinner(req, mLast);
                            mHold  = 0;
                        end else begin
                            mState = 0;
                        end
                    end else begin
                        mGuard = mGuard + 1;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [14:0] modelOutputs();
        logic [2:0] en;
        logic [7:0] gr;
        en = (mState == 1) ? 3'b001 : 3'b110;
        gr = (mState == 1) ? (8'd1 << mNum) : 8'd0;
        return {mNum, en, gr, (mState != 0)};
    endfunction

    task automatic compareOutputs(input logic [14:0] exp);
        logic [2:0] en;
        en = {arbBus.enableB0Out, arbBus.enableB1Out, arbBus.enable2Out};
        checkVal("numberOut", 32'(arbBus.numberOut), 32'(exp[14:12]));
        checkVal("enables",   32'(en),               32'(exp[11:9]));
        checkVal("grantOut",  32'(arbBus.grantOut),  32'(exp[8:1]));
        checkVal("busyOut",   32'(arbBus.busyOut),   32'(exp[0]));
    endtask

    // Drive one request vector across one clock edge and score the result.
    task automatic stepCycle(input logic [7:0] req);
        logic [14:0] exp;
        arbBus.requestIn = req;
        modelStep(req, rst);
        expQueue.push_back(modelOutputs());
        @(posedge clk);
        #1;
        cycleNum++;
        if (expQueue.size() == 0) begin
            checkVal("queueEmpty", 32'd1, 32'd0);
        end else begin
            exp = expQueue.pop_front();
            compareOutputs(exp);
        end
        $display("cycle %0d rst=%b req=%h num=%0d en=%b%b%b grant=%h busy=%b", cycleNum, rst, req,
                 arbBus.numberOut, arbBus.enableB0Out, arbBus.enableB1Out, arbBus.enable2Out,
                 arbBus.grantOut, arbBus.busyOut);
    endtask

    initial begin
        logic [7:0] holderBit;
        logic [7:0] rndReq;

        // T1: reset held with all agents requesting
        rst = 1'b1;
        arbBus.requestIn = 8'hFF;
        modelReset();
        #1;
        compareOutputs(modelOutputs());
        for (int i = 0; i < 3; i++) stepCycle(8'hFF);
        rst = 1'b0;
        stepCycle(8'h00);

        // T2: single agent 5 requests for three grant cycles
        for (int i = 0; i < 3; i++) stepCycle(8'h20);
        for (int i = 0; i < 3; i++) stepCycle(8'h00);

        // T3: agents 0 and 7 alternate, each drops after two grant cycles
        stepCycle(8'h81);
        for (int n = 0; n < 4; n++) begin
            stepCycle(8'h81);
            holderBit = 8'd1 << mNum;
            stepCycle(8'h81 & ~holderBit);
            stepCycle(8'h81);
        end
        for (int i = 0; i < 4; i++) stepCycle(8'h00);

        // T4: agent 2 holds its request; timeout build cycles grant/guard
        for (int i = 0; i < 14; i++) stepCycle(8'h04);
        for (int i = 0; i < 3; i++) stepCycle(8'h00);

        // T5: asynchronous reset in the middle of a grant
        stepCycle(8'h10);
        stepCycle(8'h10);
        #3;
        rst = 1'b1;
        #1;
        checkVal("asyncRstEnables", 32'({arbBus.enableB0Out, arbBus.enableB1Out, arbBus.enable2Out}), 32'(3'b110));
        checkVal("asyncRstGrant",   32'(arbBus.grantOut), 32'd0);
        checkVal("asyncRstBusy",    32'(arbBus.busyOut),  32'd0);
        modelReset();
        stepCycle(8'h0A);
        rst = 1'b0;

        // T6: agent 1 granted, agent 0 raised mid-grant, no pre-emption
        stepCycle(8'h0A);
        stepCycle(8'h0B);
        stepCycle(8'h0B);
        stepCycle(8'h09);
        stepCycle(8'h09);
        stepCycle(8'h09);
        stepCycle(8'h01);
        stepCycle(8'h01);
        stepCycle(8'h01);
        stepCycle(8'h00);
        stepCycle(8'h00);

        // Random traffic, requests mostly sparse so grants turn over
        for (int i = 0; i < 200; i++) begin
            rndReq = 8'($urandom) & 8'($urandom);
            stepCycle(rndReq);
        end
        for (int i = 0; i < 4; i++) stepCycle(8'h00);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
